// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding IMEM requests, skid buffer and FE/DE latch.
// Optional FE_PERF_CNT_EN adds saturating fetched-word and bubble counters.
module fetch_stage #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter logic [31:0] NOP_IR = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        STALL,
    input  logic        V_DE_FE_BR_STALL,
    input  logic        BR_RESOLVE,
    input  logic        BR_TAKEN,
    input  logic [63:0] BR_TARGET,
    output logic        IMEM_REQ,
    output logic [63:0] IMEM_ADDR,
    input  logic        IMEM_RDY,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] DE_IR,
    output logic [63:0] DE_NPC,
    output logic        DE_V
`ifdef FE_PERF_CNT_EN
    ,
    output logic [31:0] FE_FETCH_CNT,
    output logic [31:0] FE_BUBBLE_CNT
`endif
);
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_BR_WAIT = 2'd2;

    logic [1:0]  state, state_nxt;
    logic [63:0] pc, pc_nxt, pc_inc;
    logic        started;
    logic [31:0] skid_ir;
    logic [63:0] skid_npc;
    logic        de_free, accept, load_fetch, load_skid, de_load;
    logic [31:0] load_ir;
    logic [63:0] load_npc;

    function automatic logic is_cf(input logic [31:0] ir);
        return ir[6:2] == 5'b11000 || ir[6:2] == 5'b11001 || ir[6:2] == 5'b11011;
    endfunction

    // started holds off the first request until one clock after reset release
    assign IMEM_REQ = started && state == ST_FETCH && !V_DE_FE_BR_STALL;
    assign IMEM_ADDR = pc;
    assign pc_inc = pc + 64'd4;
    assign de_free = !DE_V || !STALL;
    assign accept = IMEM_REQ && IMEM_RDY;
    assign load_fetch = accept && de_free;
    assign load_skid = state == ST_HOLD && de_free;
    assign de_load = load_fetch || load_skid;
    assign load_ir = load_skid ? skid_ir : IMEM_RDATA;
    assign load_npc = load_skid ? skid_npc : pc_inc;

    always_comb begin
        state_nxt = state == ST_FETCH ? (accept ? (de_free ? (is_cf(IMEM_RDATA) ? ST_BR_WAIT : ST_FETCH) : ST_HOLD) : ST_FETCH)
                  : state == ST_HOLD ? (de_free ? (is_cf(skid_ir) ? ST_BR_WAIT : ST_FETCH) : ST_HOLD)
                  : state == ST_BR_WAIT ? (BR_RESOLVE ? ST_FETCH : ST_BR_WAIT)
                  : ST_FETCH;
        pc_nxt = accept ? pc_inc
               : (state == ST_BR_WAIT && BR_RESOLVE && BR_TAKEN) ? (BR_TARGET & ~64'h3)
               : pc;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            started <= 1'b0;
            state <= ST_FETCH;
            pc <= RESET_VECTOR;
            skid_ir <= NOP_IR;
            skid_npc <= 64'h0;
            DE_IR <= NOP_IR;
            DE_NPC <= 64'h0;
            DE_V <= 1'b0;
        end else begin
            started <= 1'b1;
            state <= state_nxt;
            pc <= pc_nxt;
            if (accept && !de_free) begin
                skid_ir <= IMEM_RDATA;
                skid_npc <= pc_inc;
            end
            if (de_load) begin
                DE_IR <= load_ir;
                DE_NPC <= load_npc;
                DE_V <= 1'b1;
            end else if (DE_V && !STALL) begin
                DE_IR <= NOP_IR;
                DE_V <= 1'b0;
            end
        end
    end

`ifdef FE_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            FE_FETCH_CNT <= 32'h0;
            FE_BUBBLE_CNT <= 32'h0;
        end else begin
            if (de_load && FE_FETCH_CNT != 32'hFFFF_FFFF)
                FE_FETCH_CNT <= FE_FETCH_CNT + 32'd1;
            if (!DE_V && state != ST_BR_WAIT && FE_BUBBLE_CNT != 32'hFFFF_FFFF)
                FE_BUBBLE_CNT <= FE_BUBBLE_CNT + 32'd1;
        end
    end
`endif

    // a resolve pulse is only meaningful while a control-flow instruction is pending
    br_resolve_in_wait: assert property (@(posedge CLK) disable iff (!RESET_N) BR_RESOLVE |-> state == ST_BR_WAIT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven IMEM responder with an in-order scoreboard on DE latch consumption.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] ir;
        logic [63:0] npc;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] ir;
        int          lat;
        bit          cf;
        int          bw;
        int          stall;
        bit          taken;
        logic [63:0] tgt;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        STALL, V_DE_FE_BR_STALL, BR_RESOLVE, BR_TAKEN, IMEM_RDY;
    logic [63:0] BR_TARGET;
    logic [31:0] IMEM_RDATA;
    logic        IMEM_REQ, DE_V;
    logic [63:0] IMEM_ADDR, DE_NPC;
    logic [31:0] DE_IR;
`ifdef FE_PERF_CNT_EN
    logic [31:0] fe_fetch_cnt, fe_bubble_cnt;
    int          exp_fetch = 0;
    int          exp_bub = 0;
    bit          in_br = 0;
`endif

    exp_t sb[$];
    vec_t tbl[15];
    int   n_chk = 0;
    int   n_fail = 0;

    fetch_stage dut (
        .CLK(CLK), .RESET_N(RESET_N), .STALL(STALL), .V_DE_FE_BR_STALL(V_DE_FE_BR_STALL),
        .BR_RESOLVE(BR_RESOLVE), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDY(IMEM_RDY), .IMEM_RDATA(IMEM_RDATA),
        .DE_IR(DE_IR), .DE_NPC(DE_NPC), .DE_V(DE_V)
`ifdef FE_PERF_CNT_EN
        , .FE_FETCH_CNT(fe_fetch_cnt), .FE_BUBBLE_CNT(fe_bubble_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_req"}, {63'h0, IMEM_REQ}, 64'h0);
        chk({p, "_addr"}, IMEM_ADDR, 64'h0);
        chk({p, "_de_v"}, {63'h0, DE_V}, 64'h0);
        chk({p, "_de_ir"}, {32'h0, DE_IR}, {32'h0, NOP});
        chk({p, "_de_npc"}, DE_NPC, 64'h0);
    endtask

    // consumer side of the scoreboard: a word leaves the DE latch when DE_V && !STALL
    always @(negedge CLK) begin
        if (RESET_N === 1'b1) begin
            if (DE_V && !STALL) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'h1, 64'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("de_ir", {32'h0, DE_IR}, {32'h0, e.ir});
                    chk("de_npc", DE_NPC, e.npc);
                end
            end
            if (!DE_V) chk("de_nop", {32'h0, DE_IR}, {32'h0, NOP});
`ifdef FE_PERF_CNT_EN
            if (!DE_V && !in_br) exp_bub++;
`endif
        end
    end

    task automatic run_vec(input int i);
        vec_t v;
        int n;
        v = tbl[i];
        n = 0;
        while (IMEM_REQ !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk($sformatf("v%0d_req", i), {63'h0, IMEM_REQ}, 64'h1);
        chk($sformatf("v%0d_addr", i), IMEM_ADDR, v.addr);
        if (!v.cf && v.stall > 0) STALL = 1'b1;
        repeat (v.lat) begin
            step();
            chk($sformatf("v%0d_hold_req", i), {63'h0, IMEM_REQ}, 64'h1);
            chk($sformatf("v%0d_hold_addr", i), IMEM_ADDR, v.addr);
        end
        IMEM_RDY = 1'b1;
        IMEM_RDATA = v.ir;
        sb.push_back('{v.ir, v.addr + 64'd4});
`ifdef FE_PERF_CNT_EN
        exp_fetch++;
`endif
        step();
        IMEM_RDY = 1'b0;
        IMEM_RDATA = 32'hDEAD_BEEF;
        chk($sformatf("v%0d_de_v", i), {63'h0, DE_V}, 64'h1);
        if (v.cf) begin
`ifdef FE_PERF_CNT_EN
            in_br = 1;
`endif
            if (v.stall > 0) STALL = 1'b1;
            repeat (v.bw) begin
                chk($sformatf("v%0d_brw_req", i), {63'h0, IMEM_REQ}, 64'h0);
                step();
            end
            chk($sformatf("v%0d_brw_req", i), {63'h0, IMEM_REQ}, 64'h0);
            BR_RESOLVE = 1'b1;
            BR_TAKEN = v.taken;
            BR_TARGET = v.tgt;
            step();
            BR_RESOLVE = 1'b0;
            BR_TAKEN = 1'b0;
`ifdef FE_PERF_CNT_EN
            in_br = 0;
`endif
            chk($sformatf("v%0d_redir_req", i), {63'h0, IMEM_REQ}, 64'h1);
            if (v.stall > 0) begin
                chk($sformatf("v%0d_brstall_ir", i), {32'h0, DE_IR}, {32'h0, v.ir});
                chk($sformatf("v%0d_brstall_v", i), {63'h0, DE_V}, 64'h1);
                STALL = 1'b0;
            end
        end else if (v.stall > 0) begin
            repeat (v.stall) begin
                chk($sformatf("v%0d_skid_req", i), {63'h0, IMEM_REQ}, 64'h0);
                chk($sformatf("v%0d_skid_hold", i), {32'h0, DE_IR}, {32'h0, tbl[i-1].ir});
                step();
            end
            STALL = 1'b0;
            step();
            chk($sformatf("v%0d_skid_out", i), {32'h0, DE_IR}, {32'h0, v.ir});
            chk($sformatf("v%0d_skid_v", i), {63'h0, DE_V}, 64'h1);
        end
    endtask

    initial begin
        //          addr                     ir            lat cf bw st tk target
        tbl[0]  = '{64'h0,                   32'h00100093, 1, 0, 0, 0, 0, 64'h0};
        tbl[1]  = '{64'h4,                   32'h00100093, 1, 0, 0, 0, 0, 64'h0};
        tbl[2]  = '{64'h8,                   32'h00100093, 1, 0, 0, 0, 0, 64'h0};
        tbl[3]  = '{64'hC,                   32'h00200113, 1, 0, 0, 3, 0, 64'h0};
        tbl[4]  = '{64'h10,                  32'h00000463, 2, 1, 3, 0, 1, 64'h40};
        tbl[5]  = '{64'h40,                  32'h00000463, 1, 1, 2, 0, 0, 64'h80};
        tbl[6]  = '{64'h44,                  32'h0000006F, 3, 1, 1, 0, 1, 64'h103};
        tbl[7]  = '{64'h100,                 32'h00008067, 1, 1, 0, 1, 1, 64'h200};
        tbl[8]  = '{64'h200,                 32'h000000B7, 1, 0, 0, 0, 0, 64'h0};
        tbl[9]  = '{64'h204,                 32'h0000004F, 2, 0, 0, 0, 0, 64'h0};
        tbl[10] = '{64'h208,                 32'h00000463, 1, 1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE};
        tbl[11] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'h00300193, 1, 0, 0, 0, 0, 64'h0};
        tbl[12] = '{64'h0,                   32'h00400213, 1, 0, 0, 0, 0, 64'h0};
        tbl[13] = '{64'h0,                   32'h00600313, 1, 0, 0, 0, 0, 64'h0};
        tbl[14] = '{64'h4,                   32'h00700393, 2, 0, 0, 0, 0, 64'h0};
        STALL = 1'b0;
        V_DE_FE_BR_STALL = 1'b0;
        BR_RESOLVE = 1'b0;
        BR_TAKEN = 1'b0;
        BR_TARGET = 64'h0;
        IMEM_RDY = 1'b0;
        IMEM_RDATA = 32'h0;
        #2 RESET_N = 1'b0;
        repeat (3) step();
        chk_reset("rst");
        RESET_N = 1'b1;
        #1;
        chk("release_req", {63'h0, IMEM_REQ}, 64'h0);
        step();
        chk("first_req", {63'h0, IMEM_REQ}, 64'h1);
        for (int i = 0; i < 13; i++) run_vec(i);

        // reset while a request to 0x4 is outstanding; the late response must be dropped
        step();
        chk("mid_req", {63'h0, IMEM_REQ}, 64'h1);
        RESET_N = 1'b0;
        sb.delete();
`ifdef FE_PERF_CNT_EN
        exp_fetch = 0;
        exp_bub = 0;
        in_br = 0;
`endif
        #1;
        chk_reset("midrst");
        IMEM_RDY = 1'b1;
        IMEM_RDATA = 32'h00500293;
        step();
        step();
        RESET_N = 1'b1;
        #1;
        chk("late_rdy_req", {63'h0, IMEM_REQ}, 64'h0);
        step();
        IMEM_RDY = 1'b0;
        #1;
        chk("late_rdy_dropped", {63'h0, DE_V}, 64'h0);
        chk("post_rst_req", {63'h0, IMEM_REQ}, 64'h1);
        chk("post_rst_addr", IMEM_ADDR, 64'h0);
        run_vec(13);

        V_DE_FE_BR_STALL = 1'b1;
        #1;
        chk("brstall_req", {63'h0, IMEM_REQ}, 64'h0);
        step();
        chk("brstall_hold_req", {63'h0, IMEM_REQ}, 64'h0);
        chk("brstall_hold_addr", IMEM_ADDR, 64'h4);
        V_DE_FE_BR_STALL = 1'b0;
        #1;
        chk("brstall_release", {63'h0, IMEM_REQ}, 64'h1);
        run_vec(14);

        repeat (3) step();
        chk("sb_drained", 64'(sb.size()), 64'h0);
        chk("final_de_v", {63'h0, DE_V}, 64'h0);
`ifdef FE_PERF_CNT_EN
        chk("perf_fetch", {32'h0, fe_fetch_cnt}, 64'(exp_fetch));
        chk("perf_bubble", {32'h0, fe_bubble_cnt}, 64'(exp_bub));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
